// File: rtl/hazard_ctrl.sv
// Hazard and control unit for the 5-stage RV32I pipe: stall/flush generation,
// EX-stage forwarding selects, LSU wait FSM and saturating perf counters.
module hazard_ctrl #(
    parameter int          CNT_W      = 32,
    parameter logic [1:0]  WB_SEL_MEM = 2'b01
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             rd_wrenE,
    input  logic [1:0]       wb_selE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             rd_wrenM,
    input  logic             rd_wrenW,
    input  logic             mispredE,
    input  logic             mem_reqM,
    input  logic             mem_ackM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       fwd_aE,
    output logic [1:0]       fwd_bE,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MEM_WAIT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             state_reg;
    logic             state_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic             wait_hold;
    logic             load_use;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:      if (mem_reqM && !mem_ackM) state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ackM)              state_next = ST_RUN;
            default:                                state_next = ST_RUN;
        endcase
    end

    // The ack cycle already behaves like RUN so the pipe releases without a bubble.
    assign wait_hold = (state_reg == ST_MEM_WAIT) && !mem_ackM;

    assign load_use = (wb_selE == WB_SEL_MEM) && rd_wrenE && (rdE != 5'd0) &&
                      ((rdE == rs1D) || (rdE == rs2D));

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (!i_rst_n) begin
            stallF = 1'b0;
        end else if (wait_hold) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (mispredE) begin
            // Redirect kills the younger instructions, so a pending load-use stall is moot.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    logic [4:0] rs_e [2];
    logic [1:0] fwd  [2];

    assign rs_e[0] = rs1E;
    assign rs_e[1] = rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd[gi] = 2'b00;
                if (!i_rst_n || rs_e[gi] == 5'd0)
                    fwd[gi] = 2'b00;
                else if (rd_wrenM && rdM == rs_e[gi])
                    fwd[gi] = 2'b10;
                else if (rd_wrenW && rdW == rs_e[gi])
                    fwd[gi] = 2'b01;
            end
        end
    endgenerate

    assign fwd_aE = fwd[0];
    assign fwd_bE = fwd[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_RUN;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (stallD && stall_cnt_reg != CNT_MAX)
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            if (flushD && mispredE && flush_cnt_reg != CNT_MAX)
                flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
    assign o_flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed vectors and queues
// their expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic       clk;
    logic       i_rst_n;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       rd_wrenE, rd_wrenM, rd_wrenW, mispredE, mem_reqM, mem_ackM;
    logic [1:0] wb_selE;

    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]  fwd_aE, fwd_bE;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushW;
    logic [1:0]  s_fwd_aE, s_fwd_bE;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    hazard_ctrl dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .rd_wrenE(rd_wrenE), .wb_selE(wb_selE), .rdM(rdM), .rdW(rdW),
        .rd_wrenM(rd_wrenM), .rd_wrenW(rd_wrenW), .mispredE(mispredE),
        .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .fwd_aE(fwd_aE), .fwd_bE(fwd_bE),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .rd_wrenE(rd_wrenE), .wb_selE(wb_selE), .rdM(rdM), .rdW(rdW),
        .rd_wrenM(rd_wrenM), .rd_wrenW(rd_wrenW), .mispredE(mispredE),
        .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
        .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .stallM(s_stallM),
        .flushD(s_flushD), .flushE(s_flushE), .flushW(s_flushW),
        .fwd_aE(s_fwd_aE), .fwd_bE(s_fwd_bE),
        .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic        rd_wrenE, rd_wrenM, rd_wrenW, mispredE, mem_reqM, mem_ackM;
        logic [1:0]  wb_selE;
        logic [6:0]  ctrl;   // {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
        logic [3:0]  fwd;    // {fwd_aE,fwd_bE}
        logic [31:0] cnt_s, cnt_f;
        logic [3:0]  cnt_sat_s, cnt_sat_f;
    } vec_t;

    vec_t v;
    vec_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_WAIT = 7'b1111001;
    localparam logic [6:0] C_MP   = 7'b0000110;

    task automatic clr(input string name);
        v.name = name; v.rst_n = 1'b1;
        v.rs1D = 0; v.rs2D = 0; v.rs1E = 0; v.rs2E = 0; v.rdE = 0; v.rdM = 0; v.rdW = 0;
        v.rd_wrenE = 0; v.rd_wrenM = 0; v.rd_wrenW = 0; v.mispredE = 0;
        v.mem_reqM = 0; v.mem_ackM = 0; v.wb_selE = 2'b00;
        v.ctrl = C_NONE; v.fwd = 4'b0000;
    endtask

    task automatic load_use_in(input logic [4:0] r);
        v.wb_selE = 2'b01; v.rd_wrenE = 1'b1; v.rdE = r; v.rs1D = r;
    endtask

    task automatic issue();
        if (!v.rst_n) begin
            exp_stall = 0;
            exp_flush = 0;
        end
        v.cnt_s     = exp_stall;
        v.cnt_f     = exp_flush;
        v.cnt_sat_s = (exp_stall > 15) ? 4'd15 : exp_stall[3:0];
        v.cnt_sat_f = (exp_flush > 15) ? 4'd15 : exp_flush[3:0];
        @(posedge clk);
        #1;
        i_rst_n = v.rst_n;
        rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
        rdE = v.rdE; rdM = v.rdM; rdW = v.rdW;
        rd_wrenE = v.rd_wrenE; rd_wrenM = v.rd_wrenM; rd_wrenW = v.rd_wrenW;
        wb_selE = v.wb_selE; mispredE = v.mispredE;
        mem_reqM = v.mem_reqM; mem_ackM = v.mem_ackM;
        q.push_back(v);
        if (v.rst_n && v.ctrl[5]) exp_stall++;
        if (v.rst_n && v.ctrl[2] && v.mispredE) exp_flush++;
    endtask

    vec_t e;
    logic [6:0] act_ctrl, sat_ctrl;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act_ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
            sat_ctrl = {s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushW};
            total++;
            if (act_ctrl !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl: got %b want %b", e.name, act_ctrl, e.ctrl);
            end
            total++;
            if ({fwd_aE, fwd_bE} !== e.fwd) begin
                bad++;
                $display("FAIL %s fwd: got %b want %b", e.name, {fwd_aE, fwd_bE}, e.fwd);
            end
            total++;
            if (stall_cnt !== e.cnt_s) begin
                bad++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt_s);
            end
            total++;
            if (flush_cnt !== e.cnt_f) begin
                bad++;
                $display("FAIL %s flush_cnt: got %0d want %0d", e.name, flush_cnt, e.cnt_f);
            end
            total++;
            if ({sat_ctrl, s_fwd_aE, s_fwd_bE} !== {e.ctrl, e.fwd}) begin
                bad++;
                $display("FAIL %s sat_ctrl: got %b want %b", e.name,
                         {sat_ctrl, s_fwd_aE, s_fwd_bE}, {e.ctrl, e.fwd});
            end
            total++;
            if ({s_stall_cnt, s_flush_cnt} !== {e.cnt_sat_s, e.cnt_sat_f}) begin
                bad++;
                $display("FAIL %s sat_cnt: got %0d/%0d want %0d/%0d", e.name,
                         s_stall_cnt, s_flush_cnt, e.cnt_sat_s, e.cnt_sat_f);
            end
            $display("vec %s ctrl=%b fwd=%b stall_cnt=%0d flush_cnt=%0d sat=%0d",
                     e.name, act_ctrl, {fwd_aE, fwd_bE}, stall_cnt, flush_cnt, s_stall_cnt);
        end
    end

    initial begin
        i_rst_n = 1'b0;
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        rd_wrenE = 0; rd_wrenM = 0; rd_wrenW = 0; wb_selE = 0;
        mispredE = 0; mem_reqM = 0; mem_ackM = 0;

        // Reset gates everything even with hazards and forwarding on the inputs
        clr("reset"); v.rst_n = 1'b0; load_use_in(5'd5); v.mispredE = 1'b1;
        v.rdM = 7; v.rd_wrenM = 1; v.rs1E = 7; v.mem_reqM = 1; issue();
        clr("idle"); issue();

        clr("lu_rs1"); load_use_in(5'd5); v.ctrl = C_LU; issue();
        clr("lu_clear"); load_use_in(5'd0); issue();
        clr("lu_rs2"); v.wb_selE = 2'b01; v.rd_wrenE = 1; v.rdE = 9; v.rs2D = 9; v.ctrl = C_LU; issue();
        clr("no_load"); v.wb_selE = 2'b00; v.rd_wrenE = 1; v.rdE = 9; v.rs2D = 9; issue();
        clr("no_wren"); v.wb_selE = 2'b01; v.rd_wrenE = 0; v.rdE = 9; v.rs2D = 9; issue();

        clr("fwd_mem"); v.rdM = 7; v.rdW = 7; v.rd_wrenM = 1; v.rd_wrenW = 1; v.rs1E = 7;
        v.fwd = 4'b1000; issue();
        clr("fwd_wb"); v.rdM = 7; v.rdW = 7; v.rd_wrenM = 0; v.rd_wrenW = 1; v.rs1E = 7;
        v.fwd = 4'b0100; issue();
        clr("fwd_x0"); v.rd_wrenM = 1; v.rd_wrenW = 1; v.rs1E = 7; issue();
        clr("fwd_b"); v.rs1E = 3; v.rs2E = 4; v.rdM = 4; v.rd_wrenM = 1; v.rdW = 3; v.rd_wrenW = 1;
        v.fwd = 4'b0110; issue();

        clr("lsu_req"); v.mem_reqM = 1; issue();
        for (int i = 0; i < 3; i++) begin
            clr("lsu_wait"); v.ctrl = C_WAIT; issue();
        end
        clr("lsu_ack"); v.mem_ackM = 1; issue();
        clr("lsu_run"); issue();

        clr("mp_req"); v.mem_reqM = 1; issue();
        clr("mp_wait"); v.mispredE = 1; v.ctrl = C_WAIT; issue();
        clr("mp_wait_lu"); v.mispredE = 1; load_use_in(5'd6); v.ctrl = C_WAIT; issue();
        clr("mp_ack"); v.mispredE = 1; v.mem_ackM = 1; v.ctrl = C_MP; issue();
        clr("mp_lu"); v.mispredE = 1; load_use_in(5'd5); v.ctrl = C_MP; issue();
        clr("mp_only"); v.mispredE = 1; issue();
        v.ctrl = C_MP;
        q[q.size()-1].ctrl = C_MP;
        exp_flush++;

        for (int i = 0; i < 20; i++) begin
            clr("sat_lu"); load_use_in(5'd12); v.ctrl = C_LU; issue();
        end
        clr("sat_end"); issue();

        clr("rst_req"); v.mem_reqM = 1; issue();
        clr("rst_wait"); v.ctrl = C_WAIT; issue();
        clr("rst_mid"); v.rst_n = 1'b0; issue();
        clr("rst_run"); issue();
        clr("rst_lu"); load_use_in(5'd3); v.ctrl = C_LU; issue();
        clr("rst_end"); issue();

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
